frame_buffer_arbiter: RTL
=========================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter BURST_W, default 8, burstcount width.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum outstanding read bursts.
REQ-005 SHALL have port clk, in, 1, single clock.
REQ-006 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-007 SHALL have ports s0_address, s0_read, s0_write, s0_burstcount, s0_writedata, in, ADDR_W/1/1/BURST_W/DATA_W, requester 0 (camera writer) command.
REQ-008 SHALL have ports s0_waitrequest, s0_readdata, s0_readdatavalid, out, 1/DATA_W/1, requester 0 response.
REQ-009 SHALL have an identical s1_* port set, requester 1 (LCD reader).
REQ-010 SHALL have ports m_address, m_read, m_write, m_burstcount, m_writedata, out, ADDR_W/1/1/BURST_W/DATA_W, shared Avalon-MM master to SDRAM bridge.
REQ-011 SHALL have ports m_waitrequest, m_readdata, m_readdatavalid, in, 1/DATA_W/1, shared master response.

Function
REQ-012 SHALL use states IDLE, GRANT, WBURST; IDLE->GRANT on any request, GRANT->WBURST on accepted write first beat with burstcount>1, GRANT->IDLE on accepted read or single-beat write, WBURST->IDLE on last beat accepted.
REQ-013 SHALL arbitrate round-robin: on simultaneous requests, grant the requester not granted last; on a single request, grant it.
REQ-014 SHALL register the arbitration decision; a requester's first m_* command appears one cycle after its request is first sampled in IDLE.
REQ-015 SHALL mux the granted requester's command onto m_* and pass m_waitrequest to it; non-granted s*_waitrequest SHALL be 1.
REQ-016 SHALL hold a write grant for exactly burstcount accepted beats (beat accepted = m_write & !m_waitrequest), using a BURST_W-bit down-counter.
REQ-017 SHALL release a read grant after the read command is accepted (single command cycle).
REQ-018 SHALL push {requester id, burstcount} into a tag FIFO on each accepted read.
REQ-019 SHALL steer m_readdata/m_readdatavalid to the requester at the FIFO head, decrement its beat count per valid beat, and pop on the last beat.
REQ-020 SHALL, with MAX_OUT tags outstanding, not grant reads (waitrequest held 1) while writes remain grantable.
REQ-021 SHALL accept a read push and a final-beat pop in the same cycle without loss.
REQ-022 SHALL drive s*_readdata directly from m_readdata (no extra latency); readdatavalid only to the owning requester.
REQ-023 SHALL treat burstcount 0 as 1.

Reset
REQ-024 SHALL on reset: state IDLE, last-grant = requester 1, tag FIFO empty, m_read=m_write=0, m_burstcount=0, m_address=0, s*_readdatavalid=0, s*_waitrequest=1.
REQ-025 SHALL on reset mid-burst abandon the burst and flush outstanding tags; returned beats after reset SHALL be discarded.

Configuration
REQ-026 SHALL, when FBA_LCD_PRIORITY_EN is defined, give requester 1 strict priority over requester 0 at every IDLE decision; when undefined, round-robin per REQ-013.

Structure
REQ-027 SHALL place state enum, tag record type (id, beat count) and default parameter constants in package fba_pkg.
REQ-028 SHALL implement the tag FIFO as sub-module fba_tag_fifo (depth MAX_OUT, count, full/empty).

Verification
REQ-029 SHALL cover: s0 write burst 8 at 0x1000, m_waitrequest stalls beats 3-4 -> 8 beats on m_*, s1 waitrequest=1 throughout, grant freed after beat 8.
REQ-030 SHALL cover: s0 and s1 requesting together from reset -> grants s0, s1, s0 in turn (s1 first with FBA_LCD_PRIORITY_EN).
REQ-031 SHALL cover: s1 read burst 4, then s0 read burst 2, data returned in order -> s1 gets 4 valid beats, then s0 gets 2.
REQ-032 SHALL cover: 4 outstanding reads with MAX_OUT=4 -> 5th read stalled until first tag pops; a pending write still granted.
REQ-033 SHALL cover: reset asserted in beat 5 of an 8-beat write -> next cycle m_write=0, state IDLE, FIFO empty.
REQ-034 SHALL cover: read push and final-beat pop same cycle -> FIFO count unchanged, next head correct.

Source files
------------

// File: rtl/fba_pkg.sv
// Shared types and default sizing for the frame buffer arbiter.
// Included by the arbiter top and by its tag FIFO.
package fba_pkg;

    localparam int FBA_ADDR_W      = 32;
    localparam int FBA_DATA_W      = 32;
    localparam int FBA_BURST_W     = 8;
    localparam int FBA_MAX_OUT     = 4;
    // Tag beat field width. BURST_W must not exceed it.
    localparam int FBA_TAG_BEATS_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WBURST = 2'd2
    } fba_state_e;

    typedef struct packed {
        logic                       id;
        logic [FBA_TAG_BEATS_W-1:0] beats;
    } fba_tag_t;

    // A burstcount of zero means one beat.
    function automatic logic [FBA_TAG_BEATS_W-1:0] fba_beats(input logic [FBA_TAG_BEATS_W-1:0] bc);
        return (bc == '0) ? FBA_TAG_BEATS_W'(1) : bc;
    endfunction

endpackage

// File: rtl/fba_tag_fifo.sv
// Tag FIFO for outstanding read bursts: each entry records which requester
// owns the burst and how many beats it returns.
module fba_tag_fifo
    import fba_pkg::*;
#(
    parameter int DEPTH = FBA_MAX_OUT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  fba_tag_t push_tag,
    input  logic     pop,
    output fba_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fba_tag_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: tag storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Two-requester Avalon-MM arbiter (camera writer s0, LCD reader s1) onto one SDRAM master.
// Define FBA_LCD_PRIORITY_EN to give s1 strict priority instead of round-robin.
module frame_buffer_arbiter
    import fba_pkg::*;
#(
    parameter int ADDR_W  = FBA_ADDR_W,
    parameter int DATA_W  = FBA_DATA_W,
    parameter int BURST_W = FBA_BURST_W,
    parameter int MAX_OUT = FBA_MAX_OUT
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [ADDR_W-1:0]  s0_address,
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [BURST_W-1:0] s0_burstcount,
    input  logic [DATA_W-1:0]  s0_writedata,
    output logic               s0_waitrequest,
    output logic [DATA_W-1:0]  s0_readdata,
    output logic               s0_readdatavalid,

    input  logic [ADDR_W-1:0]  s1_address,
    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [BURST_W-1:0] s1_burstcount,
    input  logic [DATA_W-1:0]  s1_writedata,
    output logic               s1_waitrequest,
    output logic [DATA_W-1:0]  s1_readdata,
    output logic               s1_readdatavalid,

    output logic [ADDR_W-1:0]  m_address,
    output logic               m_read,
    output logic               m_write,
    output logic [BURST_W-1:0] m_burstcount,
    output logic [DATA_W-1:0]  m_writedata,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid
);

    fba_state_e                 state;
    fba_state_e                 state_next;
    logic                       grant_id;     // current owner; also the last-granted requester
    logic                       pick_id;
    logic [BURST_W-1:0]         wr_left;
    logic [FBA_TAG_BEATS_W-1:0] rd_beat_cnt;

    logic                       elig0;
    logic                       elig1;
    logic                       sel_read;
    logic                       sel_write;
    logic                       rd_cmd;
    logic [ADDR_W-1:0]          sel_address;
    logic [BURST_W-1:0]         sel_burst;
    logic [DATA_W-1:0]          sel_writedata;
    logic [FBA_TAG_BEATS_W-1:0] sel_beats;
    logic                       rd_accept;
    logic                       wr_accept;
    logic                       rd_beat;
    logic                       last_rd_beat;
    fba_tag_t                   push_tag;
    fba_tag_t                   head_tag;
    logic                       fifo_full;
    logic                       fifo_empty;

    // Reads are only eligible while a tag slot is free; writes always are.
    assign elig0 = s0_write | (s0_read & !fifo_full);
    assign elig1 = s1_write | (s1_read & !fifo_full);

`ifdef FBA_LCD_PRIORITY_EN
    assign pick_id = elig1;
`else
    assign pick_id = (elig0 & elig1) ? ~grant_id : elig1;
`endif

    assign sel_read      = grant_id ? s1_read       : s0_read;
    assign sel_write     = grant_id ? s1_write      : s0_write;
    assign sel_address   = grant_id ? s1_address    : s0_address;
    assign sel_burst     = grant_id ? s1_burstcount : s0_burstcount;
    assign sel_writedata = grant_id ? s1_writedata  : s0_writedata;
    assign sel_beats     = fba_beats(FBA_TAG_BEATS_W'(sel_burst));
    assign rd_cmd        = sel_read & !sel_write;

    assign rd_accept = (state == GRANT) & rd_cmd & !m_waitrequest;
    assign wr_accept = (state != IDLE) & sel_write & !m_waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (elig0 | elig1) state_next = GRANT;
            end
            GRANT: begin
                if (wr_accept)
                    state_next = (sel_beats != FBA_TAG_BEATS_W'(1)) ? WBURST : IDLE;
                else if (rd_accept || (!sel_read && !sel_write))
                    state_next = IDLE;
            end
            WBURST: begin
                if (wr_accept && wr_left == BURST_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_burstcount   = '0;
        m_writedata    = '0;
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        if (state != IDLE) begin
            m_address    = sel_address;
            m_burstcount = BURST_W'(sel_beats);
            m_writedata  = sel_writedata;
            m_write      = sel_write;
            m_read       = (state == GRANT) & rd_cmd;
            if (grant_id) s1_waitrequest = m_waitrequest;
            else          s0_waitrequest = m_waitrequest;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id    <= 1'b1;
            wr_left     <= '0;
            rd_beat_cnt <= '0;
        end else begin
            if (state == IDLE && (elig0 | elig1)) grant_id <= pick_id;

            if (state == GRANT && wr_accept)       wr_left <= BURST_W'(sel_beats - 1'b1);
            else if (state == WBURST && wr_accept) wr_left <= wr_left - 1'b1;

            if (rd_beat) rd_beat_cnt <= last_rd_beat ? '0 : rd_beat_cnt + 1'b1;
        end
    end

    // Beats returned with no tag outstanding (e.g. after a reset) belong to nobody.
    assign rd_beat      = m_readdatavalid & !fifo_empty;
    assign last_rd_beat = rd_beat & ((rd_beat_cnt + 1'b1) == head_tag.beats);

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = rd_beat & !head_tag.id;
    assign s1_readdatavalid = rd_beat &  head_tag.id;

    assign push_tag = '{id: grant_id, beats: sel_beats};

    fba_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_accept),
        .push_tag (push_tag),
        .pop      (last_rd_beat),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
